// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the timekeeping logic and the seven-segment scan driver.
// The master side supplies digit codes and display modes; the slave side drives the display.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    hex_mode;
    logic                    lz_suppress;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;

    modport master (
        output digits_in, load, hex_mode, lz_suppress, blank_mask, blink_mask,
        input  seg_out, dig_sel, frame_done
    );

    modport slave (
        input  digits_in, load, hex_mode, lz_suppress, blank_mask, blink_mask,
        output seg_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment driver with frame-synchronous digit update.
// Define SEG7_BLINK_EN to enable the blink counter and blink_mask.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] P_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    wrap_q;
    logic                    tick;
    logic                    wrap;
    logic                    blink_phase;

    assign tick = (pcnt == P_LAST);
    assign wrap = tick && (idx == IDX_LAST);

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] bcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (bcnt == B_LAST) begin
            bcnt        <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end
`else
    logic unused_blink;
    assign blink_phase  = 1'b0;
    assign unused_blink = ^{bus.blink_mask, BLINK_DIV[0]};
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0:    seg_decode = 7'b0111111;
            4'h1:    seg_decode = 7'b0000110;
            4'h2:    seg_decode = 7'b1011011;
            4'h3:    seg_decode = 7'b1001111;
            4'h4:    seg_decode = 7'b1100110;
            4'h5:    seg_decode = 7'b1101101;
            4'h6:    seg_decode = 7'b1111101;
            4'h7:    seg_decode = 7'b0000111;
            4'h8:    seg_decode = 7'b1111111;
            4'h9:    seg_decode = 7'b1101111;
            4'hA:    seg_decode = 7'b1110111;
            4'hB:    seg_decode = 7'b1111100;
            4'hC:    seg_decode = 7'b0111001;
            4'hD:    seg_decode = 7'b1011110;
            4'hE:    seg_decode = 7'b1111001;
            default: seg_decode = 7'b1110001;
        endcase
    endfunction

    logic [3:0]            codes [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  hi_clear;
    logic [3:0]            cur_code;
    logic                  cur_blank;
    logic [6:0]            pattern;
    logic [NUM_DIGITS-1:0] sel_onehot;

    // Leading-zero chain runs from the top digit down; a higher digit that is
    // statically blanked (mask or invalid code) counts as empty, blinking does not.
    always_comb begin
        hi_clear = 1'b1;
        lz_blank = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            codes[i] = active[4*i +: 4];
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            lz_blank[NUM_DIGITS-1-i] = hi_clear && (codes[NUM_DIGITS-1-i] == 4'd0)
                                       && (i != NUM_DIGITS - 1);
            hi_clear = hi_clear && ((codes[NUM_DIGITS-1-i] == 4'd0)
                                    || bus.blank_mask[NUM_DIGITS-1-i]
                                    || ((codes[NUM_DIGITS-1-i] > 4'd9) && !bus.hex_mode));
        end
        cur_code  = codes[idx];
        cur_blank = bus.blank_mask[idx]
                    || ((cur_code > 4'd9) && !bus.hex_mode)
                    || (bus.lz_suppress && lz_blank[idx])
                    || (blink_phase && bus.blink_mask[idx]);
        pattern   = cur_blank ? 7'b0000000 : seg_decode(cur_code);
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt           <= '0;
            idx            <= '0;
            pending        <= '0;
            active         <= '0;
            wrap_q         <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.seg_out    <= {7{SEG_INV}};
            bus.dig_sel    <= {NUM_DIGITS{DIG_INV}};
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (bus.load) begin
                pending <= bus.digits_in;
            end
            if (wrap) begin
                active <= bus.load ? bus.digits_in : pending;
            end
            // Pulse lines up with the first registered digit-0 output of the new frame.
            wrap_q         <= wrap;
            bus.frame_done <= wrap_q;
            bus.seg_out    <= pattern ^ {7{SEG_INV}};
            bus.dig_sel    <= sel_onehot ^ {NUM_DIGITS{DIG_INV}};
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: per-cycle reference model plus fixed scenarios.
// Honours SEG7_BLINK_EN the same way as the design.
module tb_seg7_scan_ctrl;
    localparam int ND    = 6;
    localparam int SDIV  = 4;
    localparam int BDIV  = 64;
    localparam int FRAME = ND * SDIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .SCAN_DIV(SDIV), .BLINK_DIV(BDIV),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    // ---------------- reference model ----------------
    int          mc;
    logic [23:0] m_pend, m_act;
    logic [6:0]  exp_seg;
    logic [5:0]  exp_dig;
    logic        exp_fd;

    function automatic logic blink_on(input int c);
`ifdef SEG7_BLINK_EN
        return ((c / BDIV) % 2) == 1;
`else
        return (c < 0);
`endif
    endfunction

    function automatic logic static_blank(input logic [3:0] code, input logic bm, input logic hex);
        return bm || (code > 4'd9 && !hex);
    endfunction

    // Active-low segment value digit i must show.
    function automatic logic [6:0] model_seg(input int i, input logic [23:0] act, input logic hex,
                                             input logic lz, input logic [5:0] bm,
                                             input logic [5:0] blm, input logic ph);
        logic [3:0] code;
        logic [3:0] cj;
        logic       blank;
        logic       sup;
        code  = act[4*i +: 4];
        blank = static_blank(code, bm[i], hex) || (ph && blm[i]);
        if (lz && i != 0 && code == 4'd0) begin
            sup = 1'b1;
            for (int j = i + 1; j < ND; j++) begin
                cj = act[4*j +: 4];
                if (!(cj == 4'd0 || static_blank(cj, bm[j], hex))) sup = 1'b0;
            end
            if (sup) blank = 1'b1;
        end
        return blank ? 7'h7F : ~SEG_TAB[code];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc      <= 0;
            m_pend  <= '0;
            m_act   <= '0;
            exp_seg <= 7'h7F;
            exp_dig <= 6'h3F;
            exp_fd  <= 1'b0;
        end else begin
            exp_seg <= model_seg((mc / SDIV) % ND, m_act, bus.hex_mode, bus.lz_suppress,
                                 bus.blank_mask, bus.blink_mask, blink_on(mc));
            exp_dig <= ~(6'b000001 << ((mc / SDIV) % ND));
            exp_fd  <= (mc % FRAME == 0) && (mc != 0);
            if (mc % FRAME == FRAME - 1) m_act <= bus.load ? bus.digits_in : m_pend;
            if (bus.load) m_pend <= bus.digits_in;
            mc <= mc + 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("model_seg_out", {25'd0, bus.seg_out}, {25'd0, exp_seg});
        chk("model_dig_sel", {26'd0, bus.dig_sel}, {26'd0, exp_dig});
        chk("model_frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (bus.frame_done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("frame_wait", {31'd0, bus.frame_done}, 32'd1);
    endtask

    logic [6:0] cap_seg [ND];
    logic [5:0] cap_dig [ND];

    task automatic capture_here();
        for (int d = 0; d < ND; d++) begin
            cap_seg[d] = bus.seg_out;
            cap_dig[d] = bus.dig_sel;
            if (d < ND - 1) repeat (SDIV) step();
        end
    endtask

    task automatic pulse_load(input logic [23:0] v);
        bus.digits_in = v;
        bus.load      = 1'b1;
        step();
        bus.load      = 1'b0;
    endtask

    function automatic logic [23:0] rand_digits();
        logic [23:0] v;
        for (int d = 0; d < ND; d++) begin
            v[4*d +: 4] = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] e_bcd [ND];
        int s0, b0, b2, n;
        e_bcd = '{7'b0010000, 7'b0010010, 7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100};
        bus.digits_in   = '0;
        bus.load        = 1'b0;
        bus.hex_mode    = 1'b0;
        bus.lz_suppress = 1'b0;
        bus.blank_mask  = '0;
        bus.blink_mask  = '0;

        // Reset and first scan
        repeat (3) step();
        chk("reset_seg", {25'd0, bus.seg_out}, 32'h7F);
        chk("reset_dig", {26'd0, bus.dig_sel}, 32'h3F);
        rst_n = 1'b1;
        step();
        chk("first_dig", {26'd0, bus.dig_sel}, 32'b111110);
        repeat (SDIV - 1) step();
        chk("dwell_d0", {26'd0, bus.dig_sel}, 32'b111110);
        step();
        chk("next_d1", {26'd0, bus.dig_sel}, 32'b111101);
        wait_frame();
        n = 0;
        do begin step(); n++; end while (bus.frame_done !== 1'b1 && n < 60);
        chk("frame_period", n, 24);

        // BCD decode
        pulse_load(24'h235959);
        wait_frame();
        capture_here();
        for (int d = 0; d < ND; d++) begin
            chk("bcd_seg", {25'd0, cap_seg[d]}, {25'd0, e_bcd[d]});
            chk("scan_dig", {26'd0, cap_dig[d]}, {26'd0, ~(6'b000001 << d)});
        end

        // Mid-frame load stays hidden until the wrap
        wait_frame();
        repeat (8) step();
        pulse_load(24'h111111);
        chk("tear_old", {25'd0, bus.seg_out}, 32'b0010000);
        wait_frame();
        capture_here();
        for (int d = 0; d < ND; d++) chk("tear_new", {25'd0, cap_seg[d]}, 32'b1111001);

        // Load coinciding with wrap, plus leading-zero and invalid-code blanking
        step(); step();
        bus.hex_mode    = 1'b0;
        bus.lz_suppress = 1'b1;
        pulse_load(24'h0000A0);
        step();
        chk("wrap_load_fd", {31'd0, bus.frame_done}, 32'd1);
        capture_here();
        chk("lz_d0", {25'd0, cap_seg[0]}, 32'b1000000);
        for (int d = 1; d < ND; d++) chk("lz_blank", {25'd0, cap_seg[d]}, 32'h7F);

        bus.hex_mode = 1'b1;
        wait_frame();
        capture_here();
        chk("hex_d0", {25'd0, cap_seg[0]}, 32'b1000000);
        chk("hex_d1", {25'd0, cap_seg[1]}, 32'b0001000);
        for (int d = 2; d < ND; d++) chk("hex_lz_blank", {25'd0, cap_seg[d]}, 32'h7F);

        // Blink
        bus.lz_suppress = 1'b0;
        bus.blink_mask  = 6'b000011;
        pulse_load(24'h123456);
        s0 = 0; b0 = 0; b2 = 0;
        for (int k = 0; k < 384; k++) begin
            step();
            if (bus.dig_sel === 6'b111110) begin
                s0++;
                if (bus.seg_out === 7'h7F) b0++;
            end
            if (bus.dig_sel === 6'b111011 && bus.seg_out === 7'h7F) b2++;
        end
`ifdef SEG7_BLINK_EN
        chk("blink_d0_toggles", {31'd0, (b0 > 0 && b0 < s0)}, 32'd1);
`else
        chk("blink_d0_steady", b0, 0);
`endif
        chk("blink_d2_steady", b2, 0);

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            bus.load      = ($urandom_range(7) == 0);
            bus.digits_in = rand_digits();
            if ($urandom_range(31) == 0) begin
                bus.hex_mode    = 1'($urandom_range(1));
                bus.lz_suppress = 1'($urandom_range(1));
                bus.blank_mask  = ($urandom_range(2) == 0) ? 6'($urandom) : 6'h00;
                bus.blink_mask  = 6'($urandom);
            end
            step();
        end
        bus.load        = 1'b0;
        bus.blank_mask  = '0;
        bus.blink_mask  = '0;
        bus.lz_suppress = 1'b0;

        // Asynchronous reset mid-scan
        n = 0;
        while (bus.dig_sel !== 6'b110111 && n < 40) begin step(); n++; end
        chk("reach_d3", {26'd0, bus.dig_sel}, 32'b110111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg", {25'd0, bus.seg_out}, 32'h7F);
        chk("async_dig", {26'd0, bus.dig_sel}, 32'h3F);
        chk("async_fd", {31'd0, bus.frame_done}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("restart_dig", {26'd0, bus.dig_sel}, 32'b111110);
        chk("restart_seg", {25'd0, bus.seg_out}, 32'b1000000);
        repeat (60) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
